// File: rtl/radar_cmd_pkg.sv
// Shared types for the radar pulse-train command path: command record, scheduler states,
// and the system-time width.
package radar_cmd_pkg;

    localparam int unsigned TIME_W = 48;

    typedef struct packed {
        logic [47:0]       freq;
        logic [47:0]       dfreq;
        logic [31:0]       drate;
        logic [TIME_W-1:0] tstart;
        logic [15:0]       nimp;
        logic [1:0]        cmd_type;
        logic [31:0]       ti;
        logic [31:0]       tp;
        logic [31:0]       tb1;
        logic [31:0]       tb2;
    } radar_cmd_t;

    localparam int unsigned CMD_W = $bits(radar_cmd_t);

    typedef enum logic [2:0] {IDLE, CHECK, LOAD, ARMED, RUN} sched_state_t;

endpackage

// File: rtl/cmd_fifo.sv
// Command queue: DEPTH entries, synchronous write, show-ahead head, flush and occupancy.
module cmd_fifo
    import radar_cmd_pkg::*;
#(
    parameter int unsigned DEPTH = 8
) (
    input  logic                   CLK,
    input  logic                   RESET,
    input  logic                   flush,
    input  logic                   push,
    input  logic                   pop,
    input  logic [CMD_W-1:0]       wr_data,
    output logic [CMD_W-1:0]       rd_data,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [CMD_W-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      count_q;
    logic             push_ok, pop_ok;

    assign full    = (count_q == (AW+1)'(DEPTH));
    assign empty   = (count_q == '0);
    // A full queue rejects a push even when the head leaves in the same cycle.
    assign push_ok = push && !full && !flush;
    assign pop_ok  = pop && !empty && !flush;
    assign count   = count_q;
    assign rd_data = mem[rd_ptr_q];

    always_ff @(posedge CLK) begin
        if (RESET || flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + AW'(1);
            if (push_ok && !pop_ok)      count_q <= count_q + (AW+1)'(1);
            else if (pop_ok && !push_ok) count_q <= count_q - (AW+1)'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (push_ok) mem[wr_ptr_q] <= wr_data;
    end

endmodule

// File: rtl/cmd_scheduler.sv
// Timed-command sequencer: queues host commands, drops stale ones, loads the rest into the
// pulse-train controller with a one-cycle strobe and watches for a controller that never starts.
module cmd_scheduler
    import radar_cmd_pkg::*;
#(
    parameter int unsigned DEPTH    = 8,
    parameter int unsigned LEAD     = 16,
    parameter int unsigned START_TO = 1024
) (
    input  logic                   CLK,
    input  logic                   RESET,
    input  logic                   FLUSH,
    input  logic                   CMD_WR,
    input  logic [47:0]            CMD_FREQ,
    input  logic [47:0]            CMD_DFREQ,
    input  logic [31:0]            CMD_DRATE,
    input  logic [47:0]            CMD_TSTART,
    input  logic [15:0]            CMD_NIMP,
    input  logic [1:0]             CMD_TYPE,
    input  logic [31:0]            CMD_TI,
    input  logic [31:0]            CMD_TP,
    input  logic [31:0]            CMD_TB1,
    input  logic [31:0]            CMD_TB2,
    input  logic [47:0]            TIME_NOW,
    input  logic                   SLAVE_BUSY,
    output logic                   CMD_FULL,
    output logic [$clog2(DEPTH):0] CMD_COUNT,
    output logic                   WR_DATA,
    output logic [47:0]            MEM_FREQ,
    output logic [47:0]            MEM_DFREQ,
    output logic [31:0]            MEM_DRATE,
    output logic [47:0]            MEM_TSTART,
    output logic [15:0]            MEM_NIMP,
    output logic [1:0]             MEM_TYPE,
    output logic [31:0]            MEM_TI,
    output logic [31:0]            MEM_TP,
    output logic [31:0]            MEM_TB1,
    output logic [31:0]            MEM_TB2,
    output logic [15:0]            DROP_CNT,
    output logic [15:0]            OVF_CNT,
    output logic                   TIMEOUT
);

    sched_state_t      state_q, state_d;
    radar_cmd_t        cmd_in, head, mem_q;
    logic              fifo_empty, pop, load, drop, timeout_set, ovf;
    logic              stale_q, late_q;
    logic [15:0]       drop_q, ovf_q;
    logic              timeout_q;
    logic [TIME_W-1:0] now_next, slack, elapsed;

    assign cmd_in = {CMD_FREQ, CMD_DFREQ, CMD_DRATE, CMD_TSTART, CMD_NIMP, CMD_TYPE,
                     CMD_TI, CMD_TP, CMD_TB1, CMD_TB2};

    cmd_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .CLK    (CLK),
        .RESET  (RESET),
        .flush  (FLUSH),
        .push   (CMD_WR),
        .pop    (pop),
        .wr_data(cmd_in),
        .rd_data(head),
        .count  (CMD_COUNT),
        .full   (CMD_FULL),
        .empty  (fifo_empty)
    );

    // Comparisons are registered one cycle early against next cycle's time, so the
    // result is ready in the state that consumes it (CHECK / ARMED).
    assign now_next = TIME_NOW + TIME_W'(1);
    assign slack    = head.tstart - now_next;
    assign elapsed  = now_next - mem_q.tstart;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            stale_q <= 1'b1;
            late_q  <= 1'b0;
        end else begin
            stale_q <= $signed(slack) < $signed(TIME_W'(LEAD));
            late_q  <= $signed(elapsed) > $signed(TIME_W'(START_TO));
        end
    end

    always_comb begin
        state_d     = state_q;
        pop         = 1'b0;
        load        = 1'b0;
        drop        = 1'b0;
        timeout_set = 1'b0;
        unique case (state_q)
            IDLE: if (!fifo_empty && !SLAVE_BUSY) state_d = CHECK;
            CHECK: begin
                pop = 1'b1;
                if (stale_q) begin
                    drop    = 1'b1;
                    state_d = IDLE;
                end else begin
                    load    = 1'b1;
                    state_d = LOAD;
                end
            end
            LOAD: state_d = ARMED;
            ARMED: begin
                if (SLAVE_BUSY) begin
                    state_d = RUN;
                end else if (late_q) begin
                    timeout_set = 1'b1;
                    state_d     = IDLE;
                end
            end
            RUN: if (!SLAVE_BUSY) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (FLUSH) begin
            state_d     = IDLE;
            pop         = 1'b0;
            load        = 1'b0;
            drop        = 1'b0;
            timeout_set = 1'b0;
        end
    end

    assign ovf = CMD_WR && CMD_FULL && !FLUSH;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q       <= IDLE;
            mem_q         <= '0;
            mem_q.tstart  <= '1;
            drop_q        <= '0;
            ovf_q         <= '0;
            timeout_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            if (load) mem_q <= head;
            if (drop && drop_q != 16'hFFFF) drop_q <= drop_q + 16'd1;
            if (ovf && ovf_q != 16'hFFFF)   ovf_q  <= ovf_q + 16'd1;
            if (timeout_set) timeout_q <= 1'b1;
        end
    end

    assign WR_DATA    = (state_q == LOAD);
    assign DROP_CNT   = drop_q;
    assign OVF_CNT    = ovf_q;
    assign TIMEOUT    = timeout_q;
    assign MEM_FREQ   = mem_q.freq;
    assign MEM_DFREQ  = mem_q.dfreq;
    assign MEM_DRATE  = mem_q.drate;
    assign MEM_TSTART = mem_q.tstart;
    assign MEM_NIMP   = mem_q.nimp;
    assign MEM_TYPE   = mem_q.cmd_type;
    assign MEM_TI     = mem_q.ti;
    assign MEM_TP     = mem_q.tp;
    assign MEM_TB1    = mem_q.tb1;
    assign MEM_TB2    = mem_q.tb2;

endmodule
